// File: rtl/xb_fifo128_source.sv
// xb_fifo128_source: packs a 32-bit FWFT host stream into 128-bit entries
// and presents them to an IP through the responder side of an ap_fifo read
// port. Up to DEPTH packed entries are buffered; the head entry is visible
// combinationally on in_r_dout (first-word-fall-through).
module xb_fifo128_source #(
  parameter int DEPTH = 4
) (
  input  logic                     ip_clk,
  input  logic                     ip_rst_n,
  input  logic [31:0]              host_din,
  input  logic                     host_empty,
  output logic                     host_rden,
  input  logic                     flush,
  output logic [127:0]             in_r_dout,
  output logic                     in_r_empty_n,
  input  logic                     in_r_read,
  output logic [$clog2(DEPTH):0]   fill_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic           sync_r;
  logic           run_r;
  logic [1:0]     lane_r;
  logic [95:0]    pack_r;
  logic [127:0]   mem_r [DEPTH];
  logic [AW-1:0]  wr_ptr_r;
  logic [AW-1:0]  rd_ptr_r;
  logic [CW-1:0]  count_r;

  logic           pop_s;
  logic           consume_s;
  logic           push_s;
  logic           space_s;

  // Reset release synchroniser: assertion is immediate, release takes two edges.
  always_ff @(posedge ip_clk or negedge ip_rst_n) begin
    if (!ip_rst_n) begin
      sync_r <= 1'b0;
      run_r  <= 1'b0;
    end else begin
      sync_r <= 1'b1;
      run_r  <= sync_r;
    end
  end

  // Handshake decode: pop when the IP reads a non-empty buffer, consume a host
  // word when there is room in the packer or the buffer (a same-cycle pop
  // frees a slot for the lane-3 push).
  always_comb begin
    pop_s     = 1'b0;
    consume_s = 1'b0;
    push_s    = 1'b0;
    space_s   = 1'b0;
    if (run_r && !flush) begin
      pop_s     = in_r_read && (count_r != {CW{1'b0}});
      space_s   = (lane_r != 2'd3) || (count_r < DEPTH_C) || pop_s;
      consume_s = !host_empty && space_s;
      push_s    = consume_s && (lane_r == 2'd3);
    end else begin
      pop_s     = 1'b0;
      consume_s = 1'b0;
      push_s    = 1'b0;
      space_s   = 1'b0;
    end
  end

  // Packer: collect lanes 0..2 into the holding register; lane 3 is taken
  // straight from host_din when the entry is pushed.
  always_ff @(posedge ip_clk or negedge ip_rst_n) begin
    if (!ip_rst_n) begin
      lane_r <= 2'd0;
      pack_r <= 96'h0;
    end else if (flush) begin
      lane_r <= 2'd0;
    end else if (consume_s) begin
      case (lane_r)
        2'd0:    pack_r[31:0]  <= host_din;
        2'd1:    pack_r[63:32] <= host_din;
        2'd2:    pack_r[95:64] <= host_din;
        default: pack_r        <= pack_r;
      endcase
      lane_r <= lane_r + 2'd1;
    end
  end

  // Entry storage: cleared on reset so the head reads zero until data arrives.
  always_ff @(posedge ip_clk or negedge ip_rst_n) begin
    if (!ip_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 128'h0;
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= {host_din, pack_r};
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge ip_clk or negedge ip_rst_n) begin
    if (!ip_rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign host_rden    = consume_s;
  assign in_r_dout    = mem_r[rd_ptr_r];
  assign in_r_empty_n = (count_r != {CW{1'b0}});
  assign fill_level   = count_r;

endmodule
